// File: rtl/spart_tx_scheduler_pkg.sv
// Shared definitions for the SPART transmit scheduler: bus register
// addresses and the scheduler FSM state encoding.
package spart_tx_scheduler_pkg;

  localparam logic [1:0] ADDR_TX_DATA = 2'b00;
  localparam logic [1:0] ADDR_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_DB_LO   = 2'b10;
  localparam logic [1:0] ADDR_DB_HI   = 2'b11;

  typedef enum logic [2:0] {
    ST_CFG_LO = 3'd0,
    ST_CFG_HI = 3'd1,
    ST_IDLE   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_SETTLE = 3'd4
  } state_e;

endpackage

// File: rtl/spart_tx_scheduler_rr_select.sv
// Round-robin requester selector: picks the first set request searching
// upward from last_grant+1, wrapping modulo NUM_REQ.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   sel
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    sel   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (req[idx]) begin
        valid = 1'b1;
        sel   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spart_tx_scheduler.sv
// Writes the SPART baud divisor after reset, then arbitrates transmit
// requesters round-robin and writes one character per three cycles.
module spart_tx_scheduler
  import spart_tx_scheduler_pkg::*;
#(
  parameter int          NUM_REQ  = 4,
  parameter logic [15:0] BAUD_DIV = 16'd325
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic                 tbr,
  output logic                 iocs,
  output logic                 iorw,
  output logic [1:0]           ioaddr,
  output logic [7:0]           data_out,
  output logic                 data_oe,
  output logic                 cfg_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [7:0]       char_q, char_d;
  logic             cfg_done_q, cfg_done_d;
  logic             rr_valid;
  logic [IDX_W-1:0] rr_sel;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (rr_valid),
    .sel        (rr_sel)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    char_d       = char_q;
    cfg_done_d   = cfg_done_q;
    case (state_q)
      ST_CFG_LO: state_d = ST_CFG_HI;
      ST_CFG_HI: begin
        state_d    = ST_IDLE;
        cfg_done_d = 1'b1;
      end
      ST_IDLE: begin
        if (tbr && rr_valid) begin
          sel_d   = rr_sel;
          state_d = ST_WRITE;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_sel == IDX_W'(i)) char_d = req_data[8*i +: 8];
          end
        end
      end
      ST_WRITE: begin
        last_grant_d = sel_q;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_CFG_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CFG_LO;
      sel_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      char_q       <= 8'h00;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      char_q       <= char_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  // Bus outputs decode only flopped state; rst gating keeps the bus quiet
  // while reset is held even though the state already sits in CFG_LO.
  always_comb begin
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = ADDR_TX_DATA;
    data_out = 8'h00;
    gnt      = '0;
    if (!rst) begin
      case (state_q)
        ST_CFG_LO: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          ioaddr   = ADDR_DB_LO;
          data_out = BAUD_DIV[7:0];
        end
        ST_CFG_HI: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          ioaddr   = ADDR_DB_HI;
          data_out = BAUD_DIV[15:8];
        end
        ST_WRITE: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          ioaddr   = ADDR_TX_DATA;
          data_out = char_q;
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = (sel_q == IDX_W'(i));
          end
        end
        default: ;
      endcase
    end
  end

  assign data_oe  = iocs & ~iorw;
  assign cfg_done = cfg_done_q;

endmodule
